// File: rtl/fifo_monitor.sv
// fifo_monitor
//   Occupancy, empty, error and hysteresis-pause tracking for the five FIFOs
//   of the interconnect device. Bit index in every 5-bit vector:
//   0 = MF, 1 = VC0, 2 = VC1, 3 = D0, 4 = D1.
//
// Ports
//   clk, reset               : clock, asynchronous active-high reset
//   init                     : synchronous clear of the sticky error flags
//   push, pop [4:0]          : per-FIFO write/read strobes, one op per cycle
//   Umbral_*_alto/bajo_interno: high/low pause thresholds (MF, VC pair, D pair)
//   FIFO_empties [4:0]       : count == 0 decode
//   FIFO_errors  [4:0]       : sticky overflow/underflow flags
//   pause        [4:0]       : hysteresis back-pressure
//   fill_level [5*CNT_W-1:0] : packed counts, FIFO i at [i*CNT_W +: CNT_W]
module fifo_monitor #(
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [4:0]           push,
    input  logic [4:0]           pop,
    input  logic [4:0]           Umbral_MF_alto_interno,
    input  logic [4:0]           Umbral_MF_bajo_interno,
    input  logic [4:0]           Umbral_VC_alto_interno,
    input  logic [4:0]           Umbral_VC_bajo_interno,
    input  logic [4:0]           Umbral_D_alto_interno,
    input  logic [4:0]           Umbral_D_bajo_interno,
    output logic [4:0]           FIFO_empties,
    output logic [4:0]           FIFO_errors,
    output logic [4:0]           pause,
    output logic [5*CNT_W-1:0]   fill_level
);

    // Compare counts and 5-bit thresholds at a common width so neither side
    // is truncated, whatever CNT_W is.
    localparam int CMP_W = (CNT_W > 5) ? CNT_W : 5;

    genvar i;
    generate
        for (i = 0; i < 5; i++) begin : g_fifo
            localparam int DEPTH = (i == 0) ? MF_DEPTH : ((i < 3) ? VC_DEPTH : D_DEPTH);
            localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
            localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

            logic [CNT_W-1:0] count;
            logic             err_q;
            logic             pause_q;
            logic [4:0]       alto;
            logic [4:0]       bajo;
            logic [CMP_W-1:0] cnt_x;
            logic [CMP_W-1:0] alto_x;
            logic [CMP_W-1:0] bajo_x;
            logic             is_full;
            logic             is_empty;
            logic             err_evt;

            assign alto = (i == 0) ? Umbral_MF_alto_interno :
                          (i < 3)  ? Umbral_VC_alto_interno : Umbral_D_alto_interno;
            assign bajo = (i == 0) ? Umbral_MF_bajo_interno :
                          (i < 3)  ? Umbral_VC_bajo_interno : Umbral_D_bajo_interno;

            assign cnt_x  = CMP_W'(count);
            assign alto_x = CMP_W'(alto);
            assign bajo_x = CMP_W'(bajo);

            assign is_full  = (count == DEPTH_C);
            assign is_empty = (count == '0);

            // Overflow only on a lone push; any pop of an empty FIFO underflows,
            // even when a push in the same cycle is accepted.
            assign err_evt = (push[i] & ~pop[i] & is_full) | (pop[i] & is_empty);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    count <= '0;
                end else if (push[i] && !pop[i] && !is_full) begin
                    count <= count + ONE_C;
                end else if (!push[i] && pop[i] && !is_empty) begin
                    count <= count - ONE_C;
                end else if (push[i] && pop[i] && is_empty) begin
                    count <= ONE_C;
                end
            end

            // A new error outranks init in the same cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    err_q <= 1'b0;
                end else begin
                    err_q <= err_evt | (err_q & ~init);
                end
            end

            // Hysteresis on the registered count: set wins over clear, so a
            // misprogrammed bajo >= alto still asserts pause at alto.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pause_q <= 1'b0;
                end else if (cnt_x >= alto_x) begin
                    pause_q <= 1'b1;
                end else if (cnt_x <= bajo_x) begin
                    pause_q <= 1'b0;
                end
            end

            assign FIFO_empties[i]               = is_empty;
            assign FIFO_errors[i]                = err_q;
            assign pause[i]                      = pause_q;
            assign fill_level[i*CNT_W +: CNT_W]  = count;
        end
    endgenerate

endmodule
